// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and the stall/flush sequencer.
// The master side is the datapath and the slave side is the sequencer.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_no_rs;
  logic             id_no_rt;
  logic             id_redirect;
  logic             ex_mem_to_reg;
  logic             ex_reg_wr;
  logic [REG_W-1:0] ex_wrt_dst;
  logic             mem_mem_to_reg;
  logic             mem_mem_wr;
  logic             dmem_ready;
  logic             dmem_req;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_bubble;
  logic             exmem_en;
  logic             memwb_bubble;
  logic             busy_err;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_no_rs, id_no_rt, id_redirect,
    output ex_mem_to_reg, ex_reg_wr, ex_wrt_dst,
    output mem_mem_to_reg, mem_mem_wr, dmem_ready,
    input  dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
    input  exmem_en, memwb_bubble, busy_err, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_no_rs, id_no_rt, id_redirect,
    input  ex_mem_to_reg, ex_reg_wr, ex_wrt_dst,
    input  mem_mem_to_reg, mem_mem_wr, dmem_ready,
    output dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
    output exmem_en, memwb_bubble, busy_err, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use stall, ID redirect flush,
// and a freeze FSM that waits on a multi-cycle data memory with a timeout error.
module pipeline_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_next;
  logic [CNT_W-1:0]  r_stall_count;
  logic              r_busy_err;

  logic w_mem_op;
  logic w_ex_load;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_lu_haz;
  logic w_advance;

  logic w_dmem_req;
  logic w_pc_en;
  logic w_ifid_en;
  logic w_ifid_flush;
  logic w_idex_en;
  logic w_idex_bubble;
  logic w_exmem_en;
  logic w_memwb_bubble;

  assign w_mem_op  = bus.mem_mem_to_reg | bus.mem_mem_wr;
  // A load targeting r0 never produces a value, so it cannot create a hazard.
  assign w_ex_load = bus.ex_mem_to_reg & bus.ex_reg_wr & (bus.ex_wrt_dst != '0);
  assign w_rs_hit  = !bus.id_no_rs && (bus.id_rs == bus.ex_wrt_dst);
  assign w_rt_hit  = !bus.id_no_rt && (bus.id_rt == bus.ex_wrt_dst);
  assign w_lu_haz  = w_ex_load & (w_rs_hit | w_rt_hit);

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_advance       = 1'b0;
    w_dmem_req      = 1'b0;
    w_pc_en         = 1'b0;
    w_ifid_en       = 1'b0;
    w_ifid_flush    = 1'b0;
    w_idex_en       = 1'b0;
    w_idex_bubble   = 1'b0;
    w_exmem_en      = 1'b0;
    w_memwb_bubble  = 1'b0;

    case (r_state)
      RUN: begin
        if (w_mem_op && !bus.dmem_ready) begin
          w_dmem_req      = 1'b1;
          w_memwb_bubble  = 1'b1;
          w_state_next    = MEM_WAIT;
          w_wait_cnt_next = WAIT_W'(1);
        end else begin
          w_advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        w_dmem_req = 1'b1;
        if (bus.dmem_ready) begin
          w_advance       = 1'b1;
          w_state_next    = RUN;
          w_wait_cnt_next = '0;
        end else begin
          w_memwb_bubble = 1'b1;
          if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            w_state_next = ERR;
          end else begin
            w_wait_cnt_next = r_wait_cnt + 1'b1;
          end
        end
      end
      ERR: begin
        w_memwb_bubble = 1'b1;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase

    // Normal advance; a load-use stall takes precedence over a redirect,
    // which simply re-evaluates once the bubble has gone through.
    if (w_advance) begin
      w_pc_en       = !w_lu_haz;
      w_ifid_en     = !w_lu_haz;
      w_idex_en     = 1'b1;
      w_idex_bubble = w_lu_haz;
      w_exmem_en    = 1'b1;
      w_ifid_flush  = bus.id_redirect & !w_lu_haz;
      w_dmem_req    = w_dmem_req | w_mem_op;
    end

    if (!rst) begin
      w_dmem_req     = 1'b0;
      w_pc_en        = 1'b0;
      w_ifid_en      = 1'b0;
      w_ifid_flush   = 1'b0;
      w_idex_en      = 1'b0;
      w_idex_bubble  = 1'b0;
      w_exmem_en     = 1'b0;
      w_memwb_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_stall_count <= '0;
      r_busy_err    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (!w_pc_en && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
      if (w_state_next == ERR) begin
        r_busy_err <= 1'b1;
      end
    end
  end

  assign bus.dmem_req     = w_dmem_req;
  assign bus.pc_en        = w_pc_en;
  assign bus.ifid_en      = w_ifid_en;
  assign bus.ifid_flush   = w_ifid_flush;
  assign bus.idex_en      = w_idex_en;
  assign bus.idex_bubble  = w_idex_bubble;
  assign bus.exmem_en     = w_exmem_en;
  assign bus.memwb_bubble = w_memwb_bubble;
  assign bus.busy_err     = r_busy_err;
  assign bus.stall_count  = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl: stimulus pushes expected
// control vectors, a negedge monitor pops and compares them against the DUT.
module tb_pipeline_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 5;
  localparam int EXP_W = 9 + CNT_W;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble, dmem_req, busy_err}
  localparam logic [8:0] ZERO     = 9'b000000000;
  localparam logic [8:0] NORM     = 9'b110101000;
  localparam logic [8:0] NORM_REQ = 9'b110101010;
  localparam logic [8:0] LU       = 9'b000111000;
  localparam logic [8:0] FLUSH    = 9'b111101000;
  localparam logic [8:0] MSTALL   = 9'b000000110;
  localparam logic [8:0] ERRV     = 9'b000000101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [EXP_W-1:0] q_exp[$];
  string            q_nm[$];
  int               checks   = 0;
  int               failures = 0;

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      logic [EXP_W-1:0] e;
      logic [EXP_W-1:0] g;
      string            nm;
      e  = q_exp.pop_front();
      nm = q_nm.pop_front();
      g  = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_bubble,
            bus.exmem_en, bus.memwb_bubble, bus.dmem_req, bus.busy_err, bus.stall_count};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL %s: ctl=%b cnt=%0d required ctl=%b cnt=%0d",
                 nm, g[EXP_W-1:CNT_W], g[CNT_W-1:0], e[EXP_W-1:CNT_W], e[CNT_W-1:0]);
      end else begin
        $display("ok   %s: ctl=%b cnt=%0d", nm, g[EXP_W-1:CNT_W], g[CNT_W-1:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic no_rs, input logic [4:0] rt,
                       input logic no_rt, input logic redir, input logic ld,
                       input logic wr, input logic [4:0] dst, input logic mld,
                       input logic mst, input logic rdy);
    bus.id_rs          = rs;
    bus.id_no_rs       = no_rs;
    bus.id_rt          = rt;
    bus.id_no_rt       = no_rt;
    bus.id_redirect    = redir;
    bus.ex_mem_to_reg  = ld;
    bus.ex_reg_wr      = wr;
    bus.ex_wrt_dst     = dst;
    bus.mem_mem_to_reg = mld;
    bus.mem_mem_wr     = mst;
    bus.dmem_ready     = rdy;
  endtask

  task automatic expect_out(input string nm, input logic [8:0] ctl, input int cnt);
    q_exp.push_back({ctl, CNT_W'(cnt)});
    q_nm.push_back(nm);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    idle();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);

    tick(); expect_out("reset", ZERO, 0);
    tick(); rst = 1'b1; expect_out("idle", NORM, 0);

    // Load-use on Rs, then the following cycle advances normally
    tick(); drive(5, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0); expect_out("lu_rs", LU, 0);
    tick(); idle();                                 expect_out("lu_after", NORM, 1);
    // No false stalls
    tick(); drive(5, 1, 7, 0, 0, 1, 1, 5, 0, 0, 0); expect_out("no_rs_unused", NORM, 1);
    tick(); drive(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); expect_out("no_r0", NORM, 1);
    tick(); drive(1, 1, 9, 0, 0, 1, 1, 9, 0, 0, 0); expect_out("lu_rt", LU, 1);
    tick(); idle();                                 expect_out("lu_rt_after", NORM, 2);
    tick(); drive(9, 0, 9, 0, 0, 1, 0, 9, 0, 0, 0); expect_out("no_regwr", NORM, 2);

    // Store waits 3 cycles, completes on the 4th
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); expect_out("mem_w1", MSTALL, 2);
    tick();                                         expect_out("mem_w2", MSTALL, 3);
    tick();                                         expect_out("mem_w3", MSTALL, 4);
    tick(); bus.dmem_ready = 1'b1;                  expect_out("mem_done", NORM_REQ, 5);
    tick(); idle();                                 expect_out("mem_idle", NORM, 5);

    // Redirect alone, then redirect under a load-use stall
    tick(); drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); expect_out("redir", FLUSH, 5);
    tick(); idle();                                 expect_out("redir_end", NORM, 5);
    tick(); drive(3, 0, 0, 0, 1, 1, 1, 3, 0, 0, 0); expect_out("redir_lu", LU, 5);
    tick(); drive(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); expect_out("redir_retry", FLUSH, 6);
    tick(); idle();                                 expect_out("redir_done", NORM, 6);

    // Load timeout: 1 RUN stall + 15 wait cycles, then ERR with saturating count
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      expect_out($sformatf("tmo_wait%0d", i), MSTALL, 6 + i);
    end
    for (int i = 0; i < 20; i++) begin
      tick(); expect_out($sformatf("err%0d", i), ERRV, (22 + i > 31) ? 31 : 22 + i);
    end
    tick(); rst = 1'b0;                             expect_out("err_rst", ZERO, 0);
    tick(); rst = 1'b1; idle();                     expect_out("err_recover", NORM, 0);

    // Asynchronous reset while in MEM_WAIT
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); expect_out("mw_run", MSTALL, 0);
    tick();                                         expect_out("mw_wait", MSTALL, 1);
    tick(); rst = 1'b0;                             expect_out("mw_async_rst", ZERO, 0);
    tick(); idle(); rst = 1'b1;                     expect_out("mw_release", NORM, 0);
    tick();                                         expect_out("mw_first_edge", NORM, 0);

    for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(posedge clk);
    if (q_exp.size() > 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required pending=0", q_exp.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipelined CPU (IF, ID, EX, MEM, WB). It provides:
- load-use hazard detection against the instruction in EX; the register forwarding network in ID cannot cover this case.
- control flush for taken branches and jumps resolved in ID.
- a req/ready handshake FSM that freezes the pipeline while a multi-cycle data memory completes.
It drives the enable and bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB register banks.

Parameters:
- REG_W, 5, register index width.
- CNT_W, 16, width of the stall statistics counter.
- MEM_TIMEOUT, 15, maximum wait cycles on a memory access before the error state.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs  in  REG_W  Rs index of the instruction in ID.
- id_rt  in  REG_W  Rt index of the instruction in ID.
- id_no_rs  in  1  ID instruction does not read Rs.
- id_no_rt  in  1  ID instruction does not read Rt.
- id_redirect  in  1  taken branch (BNE with Zero clear) or jump/jr resolved in ID this cycle.
- ex_mem_to_reg  in  1  instruction in EX is a load.
- ex_reg_wr  in  1  instruction in EX writes the register file.
- ex_wrt_dst  in  REG_W  destination register of the instruction in EX.
- mem_mem_to_reg  in  1  instruction in MEM is a load.
- mem_mem_wr  in  1  instruction in MEM is a store.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data memory access request.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_en  out  1  ID/EX register enable.
- idex_bubble  out  1  load NOP (all control bits zero) into ID/EX.
- exmem_en  out  1  EX/MEM register enable.
- memwb_bubble  out  1  load NOP into MEM/WB (RegWr=0).
- busy_err  out  1  sticky memory-timeout error.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- States: RUN, MEM_WAIT, ERR. The state register and counters are clocked; all control outputs are combinational from state and inputs.
- Reset (rst=0, asynchronous): state=RUN, wait_cnt=0, stall_count=0, busy_err=0.
  - While rst=0: pc_en=ifid_en=idex_en=exmem_en=0; ifid_flush=idex_bubble=memwb_bubble=0; dmem_req=0.
- mem_op = mem_mem_to_reg | mem_mem_wr.
- lu_haz is asserted when all of the following hold:
  - ex_mem_to_reg & ex_reg_wr & (ex_wrt_dst != 0)
  - and either (!id_no_rs & id_rs==ex_wrt_dst) or (!id_no_rt & id_rt==ex_wrt_dst).
- RUN, default: all enables 1, all flush/bubble 0, dmem_req=mem_op.
- RUN, mem_op & !dmem_ready (highest priority):
  - All enables 0; memwb_bubble=1.
  - Next state MEM_WAIT, wait_cnt=1.
  - Load-use and redirect handling are deferred.
- RUN, lu_haz (no memory stall):
  - pc_en=0, ifid_en=0, idex_bubble=1; EX/MEM and later stages advance.
  - Exactly one stall cycle: on the next cycle the load is in MEM and forwarding covers the dependency.
  - id_redirect is ignored this cycle (ifid_flush=0); the branch re-evaluates on the next cycle.
- RUN, id_redirect with no stall: ifid_flush=1 for one cycle; all enables 1.
- MEM_WAIT:
  - dmem_req=1, all enables 0, memwb_bubble=1.
  - When dmem_ready=1: outputs as in RUN for that cycle (the stage advances), next state RUN, wait_cnt=0.
  - When dmem_ready=0 and wait_cnt==MEM_TIMEOUT: next state ERR.
  - Otherwise wait_cnt increments.
- ERR:
  - All enables 0, memwb_bubble=1, dmem_req=0, busy_err=1.
  - Held until reset.
- stall_count increments on every clock where pc_en=0 while rst=1, including MEM_WAIT and ERR cycles; it saturates at all-ones.
- Register index 0 never causes a hazard.
- Simultaneous lu_haz and mem stall count as a single stall cycle.

Test Plan:
1. Load-use stall:
   - Stimulus: EX load (ex_mem_to_reg=1, ex_reg_wr=1, ex_wrt_dst=5); ID id_rs=5, id_no_rs=0.
   - Response: one cycle with pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1; next cycle with EX cleared, all enables 1; stall_count=1.
2. No false stall:
   - Stimulus: as scenario 1 but id_no_rs=1, id_rt=7; then ex_wrt_dst=0 with id_rs=0.
   - Response: no stall in either case; stall_count stays 0.
3. Multi-cycle memory access:
   - Stimulus: store in MEM (mem_mem_wr=1); dmem_ready low 3 cycles, then high.
   - Response: dmem_req high 4 cycles; pc_en/ifid_en/idex_en/exmem_en=0 and memwb_bubble=1 for 3 cycles; normal on the 4th; stall_count +3.
4. Memory timeout:
   - Stimulus: load in MEM; dmem_ready held 0.
   - Response: after wait_cnt reaches 15 the FSM enters ERR; busy_err=1 and dmem_req=0 persist for 20+ cycles; rst pulse low clears busy_err and stall_count and restores enables.
5. Redirect vs load-use:
   - Stimulus: id_redirect=1 with no hazard.
   - Response: ifid_flush=1 for exactly one cycle.
   - Stimulus: id_redirect=1 together with lu_haz.
   - Response: cycle 1 has idex_bubble=1 and ifid_flush=0; cycle 2, with id_redirect still 1, has ifid_flush=1.
6. Reset mid-wait:
   - Stimulus: rst driven low asynchronously (between clock edges) while in MEM_WAIT.
   - Response: dmem_req and all enables drop to 0 immediately.
   - After rst release, with mem_op=0 and no hazard: the FSM is in RUN with all enables 1 on the first edge.
